dualportram_param: RTL
======================

DUALPORTRAM_PARAM -- requirements
Module: dualportram_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits; must be a multiple of BYTE_WIDTH.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, depth = 2**ADDRESS_WIDTH words.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8, width of one byte-enable lane.
REQ-004 SHALL have parameter READ_LATENCY, default 1, legal values 1 or 2 cycles from request edge to dout.
REQ-005 SHALL have parameter WRITE_MODE, default 0, same-port read-during-write: 0 = read-first, 1 = write-first.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk  input  1  single clock for both ports, rising edge.
REQ-007 SHALL have rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have, per port p in {0,1}: cs_p  input  1  port select.
REQ-009 SHALL have we_p  input  1  write enable, high = write, low = read.
REQ-010 SHALL have oe_p  input  1  output enable for dout_p.
REQ-011 SHALL have be_p  input  DATA_WIDTH/BYTE_WIDTH  byte-lane write enables.
REQ-012 SHALL have address_p  input  ADDRESS_WIDTH  word address.
REQ-013 SHALL have din_p  input  DATA_WIDTH  write data; dout_p  output  DATA_WIDTH  read data.
REQ-014 SHALL have valid_p  output  1  high for one cycle when dout_p carries read data.
REQ-015 SHALL have collision  output  1  same-address conflict flag (see Configuration).

Function
REQ-016 SHALL sample all port inputs on rising clk; no input has combinational effect on outputs.
REQ-017 SHALL write din_p lanes with be_p[k]=1 to address_p when cs_p=1, we_p=1; lanes with be_p[k]=0 unchanged.
REQ-018 SHALL perform a read when cs_p=1, we_p=0; data reaches internal read register after 1 cycle and dout_p after READ_LATENCY cycles.
REQ-019 SHALL assert valid_p exactly READ_LATENCY cycles after each read request, aligned with its data; back-to-back reads yield back-to-back valid.
REQ-020 SHALL drive dout_p = pipeline data when oe_p=1 at the output edge, else all zeros; valid_p is independent of oe_p.
REQ-021 SHALL hold dout_p (when oe_p=1) at the last read value between reads.
REQ-022 SHALL, for a same-port write with cs_p=1, we_p=1, update the read register with old word (WRITE_MODE=0) or merged new word (WRITE_MODE=1) but assert no valid_p.
REQ-023 SHALL, on cross-port write-write to same address same cycle, let port 0 win for every lane enabled on both ports; lanes enabled on only one port take that port's data.
REQ-024 SHALL, on cross-port read-write to same address same cycle, return the pre-write (old) word to the reading port.
REQ-025 SHALL treat cs_p=0 as idle: no write, no read, valid_p=0 next latency slot.

Reset
REQ-026 SHALL, while rst_n=0, force dout_0, dout_1, valid_0, valid_1, collision, and all pipeline registers to 0 asynchronously.
REQ-027 SHALL drop reads in flight at reset assertion; no valid_p after release for requests made before reset.
REQ-028 SHALL not clear memory contents on reset; contents persist across reset.

Configuration
REQ-029 SHALL implement collision detection only when macro DPRAM_COLLISION_DETECT_EN is defined: collision pulses high one cycle after any edge where cs_0=cs_1=1, address_0=address_1, and we_0|we_1=1.
REQ-030 SHALL, without DPRAM_COLLISION_DETECT_EN, tie collision to 0 and contain no compare logic; REQ-023/024 arbitration applies in both builds.

Structure
REQ-031 SHALL place a package dualportram_pkg holding WRITE_MODE encodings (READ_FIRST=0, WRITE_FIRST=1) and the legal READ_LATENCY range constants.
REQ-032 SHALL use one sub-module dpram_rd_pipe, instantiated once per port, implementing the READ_LATENCY data/valid pipeline and oe gating.
REQ-033 SHALL check parameter legality (DATA_WIDTH % BYTE_WIDTH, READ_LATENCY in {1,2}) at elaboration and fail on violation.

Verification
REQ-034 SHALL cover: port 0 writes addresses 0..3 with data 0..3 (be all ones), port 1 reads 0..3 -> dout_1 = 0,1,2,3 with valid_1, latency 1 and 2 builds.
REQ-035 SHALL cover: write 0xAABB at addr 5, then write 0x11 with be=2'b01 -> read returns 0xAA11 (DATA_WIDTH=16).
REQ-036 SHALL cover: same-cycle writes addr 7, port 0 = 0x55, port 1 = 0x66 -> read 0x55; collision=1 next cycle with macro, 0 without.
REQ-037 SHALL cover: addr 9 holds 0x10, port 0 writes 0x20 while port 1 reads 9 -> dout_1=0x10; subsequent read -> 0x20.
REQ-038 SHALL cover: same-port write 0x33 over 0x22, WRITE_MODE 0 vs 1 -> internal read register 0x22 vs 0x33, valid_p stays 0; oe_p=0 -> dout_p=0.
REQ-039 SHALL cover: rst_n asserted with a read in flight -> outputs 0 immediately, no valid after release, memory contents unchanged on subsequent read.

Source files
------------

// File: rtl/dualportram_pkg.sv
// Shared constants for the dual-port RAM: write-mode encodings and legal read-latency range.
// No logic; imported by the RAM top and its read pipeline.
package dualportram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    typedef enum logic {
        WM_READ_FIRST  = 1'b0,
        WM_WRITE_FIRST = 1'b1
    } write_mode_e;

endpackage

// File: rtl/dpram_rd_pipe.sv
// Per-port read pipeline: read register, READ_LATENCY data/valid alignment, oe gating, 1-2 cycles.
// No backpressure: a read accepted at the port always produces its valid pulse unless reset intervenes.
module dpram_rd_pipe
    import dualportram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_load,
    input  logic                  i_rd,
    input  logic                  i_oe,
    input  logic [DATA_WIDTH-1:0] i_dat,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_valid
);

    logic [DATA_WIDTH-1:0] r_rd_dat;
    logic                  r_rd_vld;
    logic [DATA_WIDTH-1:0] r_hold;
    logic [DATA_WIDTH-1:0] r_dout;
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_out_dat;
    logic                  w_out_vld;
    logic [DATA_WIDTH-1:0] w_last;
    logic [DATA_WIDTH-1:0] w_hold_nxt;

    // w_last is the most recent read value already presented; writes never disturb it.
    generate
        if (READ_LATENCY == RD_LAT_MIN) begin : g_lat1
            assign w_out_dat  = i_dat;
            assign w_out_vld  = i_rd;
            assign w_last     = r_rd_vld ? r_rd_dat : r_hold;
            assign w_hold_nxt = w_last;
        end else begin : g_lat2
            assign w_out_dat  = r_rd_dat;
            assign w_out_vld  = r_rd_vld;
            assign w_last     = r_hold;
            assign w_hold_nxt = r_rd_vld ? r_rd_dat : r_hold;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
            r_hold   <= '0;
            r_dout   <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_load) begin
                r_rd_dat <= i_dat;
            end
            r_rd_vld <= i_rd;
            r_hold   <= w_hold_nxt;
            r_valid  <= w_out_vld;
            r_dout   <= i_oe ? (w_out_vld ? w_out_dat : w_last) : '0;
        end
    end

    assign o_dout  = r_dout;
    assign o_valid = r_valid;

endmodule

// File: rtl/dualportram_param.sv
// True dual-port byte-enable RAM, single clock, READ_LATENCY 1-2; port 0 wins same-lane write conflicts.
// No backpressure. Collision flag is built only with DPRAM_COLLISION_DETECT_EN defined, else tied low.
module dualportram_param
    import dualportram_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BYTE_WIDTH    = 8,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_MODE    = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               cs_0,
    input  logic                               we_0,
    input  logic                               oe_0,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_0,
    input  logic [ADDRESS_WIDTH-1:0]           address_0,
    input  logic [DATA_WIDTH-1:0]              din_0,
    output logic [DATA_WIDTH-1:0]              dout_0,
    output logic                               valid_0,
    input  logic                               cs_1,
    input  logic                               we_1,
    input  logic                               oe_1,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_1,
    input  logic [ADDRESS_WIDTH-1:0]           address_1,
    input  logic [DATA_WIDTH-1:0]              din_1,
    output logic [DATA_WIDTH-1:0]              dout_1,
    output logic                               valid_1,
    output logic                               collision
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;

    generate
        if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_byte_width
            $error("dualportram_param: DATA_WIDTH must be a multiple of BYTE_WIDTH");
        end
        if (READ_LATENCY < RD_LAT_MIN || READ_LATENCY > RD_LAT_MAX) begin : g_bad_latency
            $error("dualportram_param: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] w_rd_word_0;
    logic [DATA_WIDTH-1:0] w_rd_word_1;

    // Port 0 is assigned last so it overrides port 1 on lanes both ports enable.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (cs_1 && we_1 && be_1[k]) begin
                r_mem[address_1][k*BYTE_WIDTH +: BYTE_WIDTH] <= din_1[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (cs_0 && we_0 && be_0[k]) begin
                r_mem[address_0][k*BYTE_WIDTH +: BYTE_WIDTH] <= din_0[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Reads always see the pre-edge array; only a same-port write-first write sees its own merge.
    function automatic logic [DATA_WIDTH-1:0] rd_word(
        input logic                  we,
        input logic [NB-1:0]         be,
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] din
    );
        logic [DATA_WIDTH-1:0] word;
        word = old_word;
        if (we && WRITE_MODE == WRITE_FIRST) begin
            for (int k = 0; k < NB; k++) begin
                if (be[k]) begin
                    word[k*BYTE_WIDTH +: BYTE_WIDTH] = din[k*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
        return word;
    endfunction

    assign w_rd_word_0 = rd_word(we_0, be_0, r_mem[address_0], din_0);
    assign w_rd_word_1 = rd_word(we_1, be_1, r_mem[address_1], din_1);

    dpram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (cs_0),
        .i_rd    (cs_0 && !we_0),
        .i_oe    (oe_0),
        .i_dat   (w_rd_word_0),
        .o_dout  (dout_0),
        .o_valid (valid_0)
    );

    dpram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (cs_1),
        .i_rd    (cs_1 && !we_1),
        .i_oe    (oe_1),
        .i_dat   (w_rd_word_1),
        .o_dout  (dout_1),
        .o_valid (valid_1)
    );

`ifdef DPRAM_COLLISION_DETECT_EN
    logic r_collision;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collision <= 1'b0;
        end else begin
            r_collision <= cs_0 && cs_1 && (address_0 == address_1) && (we_0 || we_1);
        end
    end

    assign collision = r_collision;
`else
    assign collision = 1'b0;
`endif

endmodule
